keypad_scan_ctrl: RTL and testbench

//  Sequences a 4x4 matrix keypad: drives row strobes, samples synchronised columns, debounces

---
 rtl/keypad_pkg.sv | 13 +
 rtl/keypad_event_fifo.sv | 46 ++++
 rtl/keypad_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  // 5-bit candidate code; bit 4 set means no contact closed in the frame
  localparam logic [4:0] NOKEY = 5'h10;

  localparam logic [3:0] ROW_STROBE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef enum logic [1:0] {IDLE, DRIVE, EVAL} scan_state_e;

endpackage

// File: rtl/keypad_event_fifo.sv
// Small synchronous FIFO for key events. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module keypad_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, column synchroniser, whole-frame debounce and
// an event FIFO delivering one code per debounced press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [3:0]       row,
  input  logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             multi_key,
  output logic             overflow
);

  localparam int unsigned   DwellW    = $clog2(SETTLE_CYCLES);
  localparam int unsigned   CntW      = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]   CntMax    = CntW'(DEBOUNCE_FRAMES);

  scan_state_e       state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [15:0]       frame_q, frame_d;
  logic [4:0]        prev_cand_q, prev_cand_d;
  logic [CntW-1:0]   stable_cnt_q, stable_cnt_d;
  logic              held_q, held_d;
  logic              multi_q, multi_d;
  logic              overflow_q, overflow_d;
  logic [3:0]        col_meta_q, col_sync_q;

  logic [4:0] cand;
  logic       many;
  logic       push, pop, fifo_full, fifo_empty;

  // Frame bit r*4+c is low when row r / column c was closed.
  always_comb begin
    cand = NOKEY;
    many = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (!frame_q[i]) begin
        if (cand != NOKEY) many = 1'b1;
        cand = 5'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dwell_d      = dwell_q;
    frame_d      = frame_q;
    prev_cand_d  = prev_cand_q;
    stable_cnt_d = stable_cnt_q;
    held_d       = held_q;
    multi_d      = multi_q;
    push         = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d   = '0;
        dwell_d = '0;
        if (enable) state_d = DRIVE;
      end
      DRIVE: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            frame_d[{idx_q, 2'b00} +: 4] = col_sync_q;
            if (idx_q == 2'd3) begin
              state_d = EVAL;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end
      EVAL: begin
        state_d     = enable ? DRIVE : IDLE;
        multi_d     = many;
        prev_cand_d = cand;
        if (cand != prev_cand_q) stable_cnt_d = CntW'(1);
        else if (stable_cnt_q != CntMax) stable_cnt_d = stable_cnt_q + CntW'(1);
        // A different key while held is ignored until a release debounces.
        if (stable_cnt_d == CntMax) begin
          if (cand == NOKEY) begin
            held_d = 1'b0;
          end else if (!held_q) begin
            push   = 1'b1;
            held_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop        = key_valid && key_ready;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dwell_q      <= '0;
      frame_q      <= '1;
      prev_cand_q  <= NOKEY;
      stable_cnt_q <= '0;
      held_q       <= 1'b0;
      multi_q      <= 1'b0;
      overflow_q   <= 1'b0;
      col_meta_q   <= 4'hF;
      col_sync_q   <= 4'hF;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dwell_q      <= dwell_d;
      frame_q      <= frame_d;
      prev_cand_q  <= prev_cand_d;
      stable_cnt_q <= stable_cnt_d;
      held_q       <= held_d;
      multi_q      <= multi_d;
      overflow_q   <= overflow_d;
      col_meta_q   <= col;
      col_sync_q   <= col_meta_q;
    end
  end

  keypad_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(KEY_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(cand[KEY_W-1:0]),
    .pop      (pop),
    .head     (key_code),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign row       = (state_q == DRIVE) ? ROW_STROBE[idx_q] : 4'b1111;
  assign key_valid = !fifo_empty;
  assign key_held  = held_q;
  assign multi_key = multi_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural keypad driven from the row strobes.
module tb_keypad_scan_ctrl;

  localparam int unsigned Frame = 17;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic        key_held;
  logic        multi_key;
  logic        overflow;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_cnt   = 0;

  logic [3:0] exp_row [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};
  logic [3:0] exp_seq [4] = '{4'd1, 4'd5, 4'd10, 4'd14};

  always #5 clock = ~clock;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_FRAMES(3),
    .FIFO_DEPTH     (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .multi_key(multi_key),
    .overflow (overflow)
  );

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      if (key_valid && key_ready) ev_cnt++;
    end
  endtask

  // Align to the negedge inside an EVAL cycle (row released while scanning).
  task automatic sync_eval();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (row != 4'hF && n < 40);
    check("sync_eval", 32'(row), 32'hF);
  endtask

  task automatic press_release(input int code);
    pressed = 16'(1 << code);
    step(3 * Frame);
    pressed = '0;
    step(3 * Frame);
  endtask

  initial begin
    // 1: reset values, then the idle scan pattern
    step(3);
    check("rst_row", 32'(row), 32'hF);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    check("rst_multi", 32'(multi_key), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 18; k++) begin
      step(1);
      check("t1_row", 32'(row), 32'((k < 16) ? exp_row[k/4] : (k == 16 ? exp_row[4] : exp_row[0])));
      check("t1_valid", 32'(key_valid), 32'h0);
    end
    step(Frame - 1);

    // 2: key 9 held for five frames
    pressed = 16'(1 << 9);
    ev_cnt = 0;
    step(3 * Frame);
    check("t2_no_early_ev", 32'(ev_cnt), 32'd0);
    check("t2_held_early", 32'(key_held), 32'h0);
    step(1);
    check("t2_valid", 32'(key_valid), 32'h1);
    check("t2_code", 32'(key_code), 32'd9);
    check("t2_held", 32'(key_held), 32'h1);
    step(2 * Frame - 1);
    check("t2_one_event", 32'(ev_cnt), 32'd1);
    pressed = '0;
    step(2 * Frame + 1);
    check("t2_held_still", 32'(key_held), 32'h1);
    step(Frame);
    check("t2_released", 32'(key_held), 32'h0);
    step(Frame - 1);

    // 3: key 6 bounces for two frames then settles
    ev_cnt = 0;
    pressed = 16'(1 << 6);
    step(Frame);
    pressed = '0;
    step(Frame);
    pressed = 16'(1 << 6);
    step(2 * Frame + 1);
    check("t3_no_early_ev", 32'(ev_cnt), 32'd0);
    check("t3_held_early", 32'(key_held), 32'h0);
    step(Frame);
    check("t3_valid", 32'(key_valid), 32'h1);
    check("t3_code", 32'(key_code), 32'd6);
    check("t3_one_event", 32'(ev_cnt), 32'd1);
    step(Frame - 1);
    pressed = '0;
    step(3 * Frame);

    // 4: consumer stalled, five presses overflow a 4-deep FIFO
    key_ready = 1'b0;
    for (int i = 0; i < 4; i++) press_release(int'(exp_seq[i]));
    check("t4_ovf_not_yet", 32'(overflow), 32'h0);
    press_release(15);
    check("t4_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_valid", 32'(key_valid), 32'h1);
      check("t4_drain_code", 32'(key_code), 32'(exp_seq[i]));
      key_ready = 1'b1;
      @(negedge clock);
      key_ready = 1'b0;
    end
    check("t4_empty", 32'(key_valid), 32'h0);
    check("t4_ovf_sticky", 32'(overflow), 32'h1);
    key_ready = 1'b1;
    sync_eval();

    // 5: keys 3 and 12 together
    pressed = 16'((1 << 3) | (1 << 12));
    step(3 * Frame + 1);
    check("t5_multi", 32'(multi_key), 32'h1);
    check("t5_valid", 32'(key_valid), 32'h1);
    check("t5_code", 32'(key_code), 32'd3);
    step(Frame - 1);
    pressed = '0;
    step(Frame);
    check("t5_multi_hold", 32'(multi_key), 32'h1);
    step(1);
    check("t5_multi_clear", 32'(multi_key), 32'h0);
    step(2 * Frame);
    check("t5_released", 32'(key_held), 32'h0);
    step(Frame - 1);

    // 6: reset mid-DRIVE with a queued event, then enable dropped mid-frame
    key_ready = 1'b0;
    pressed = 16'((1 << 7) | (1 << 13));
    step(3 * Frame + 1);
    check("t6_queued", 32'(key_valid), 32'h1);
    check("t6_code", 32'(key_code), 32'd7);
    check("t6_multi", 32'(multi_key), 32'h1);
    step(5);
    reset = 1'b1;
    pressed = '0;
    step(1);
    check("t6_rst_row", 32'(row), 32'hF);
    check("t6_rst_valid", 32'(key_valid), 32'h0);
    check("t6_rst_code", 32'(key_code), 32'h0);
    check("t6_rst_held", 32'(key_held), 32'h0);
    check("t6_rst_multi", 32'(multi_key), 32'h0);
    check("t6_rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    pressed = 16'(1 << 5);
    step(2);
    check("t6_dwell1", 32'(row), 32'b1110);
    enable = 1'b0;
    step(1);
    check("t6_dwell2", 32'(row), 32'b1110);
    step(1);
    check("t6_dwell3", 32'(row), 32'b1110);
    step(1);
    check("t6_idle_row", 32'(row), 32'hF);
    step(6 * Frame);
    check("t6_idle_row_late", 32'(row), 32'hF);
    check("t6_no_event", 32'(key_valid), 32'h0);
    check("t6_not_held", 32'(key_held), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
